// File: rtl/dmem_pkg.sv
// -----------------------------------------------------------------------------
// dmem_pkg
// Shared definitions for the latency-controlled data memory:
//   state_t        controller FSM states (IDLE, BUSY, RESP)
//   TOHOST_DEFAULT default byte address of the MMIO halt register
//   CNT_W          latency down-counter width (LATENCY-1 fits for LATENCY 1..8)
//   merge_be()     byte-lane merge of a new word over an old word
// -----------------------------------------------------------------------------
package dmem_pkg;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      BUSY = 2'd1,
      RESP = 2'd2
   } state_t;

   localparam logic [31:0] TOHOST_DEFAULT = 32'h0000_1000;
   localparam int          CNT_W          = 3;

   // The merge works on the widest supported word; callers zero-extend their
   // operands and truncate the result back to their own DATA_W.
   localparam int MAX_DATA_W = 64;
   localparam int MAX_BE_W   = MAX_DATA_W / 8;

   function automatic logic [MAX_DATA_W-1:0] merge_be(
      input logic [MAX_DATA_W-1:0] old_word,
      input logic [MAX_DATA_W-1:0] new_word,
      input logic [MAX_BE_W-1:0]   be
   );
      logic [MAX_DATA_W-1:0] merged;
      merged = old_word;
      for (int i = 0; i < MAX_BE_W; i++) begin
         if (be[i]) begin
            merged[i*8 +: 8] = new_word[i*8 +: 8];
         end
      end
      return merged;
   endfunction

endpackage

// File: rtl/dmem_latency_ctrl_if.sv
// -----------------------------------------------------------------------------
// dmem_latency_ctrl_if
// Request/response bus between the core memory stage (master) and the
// data-memory controller (slave).
//   req_valid/req_ready  request handshake
//   req_we, req_addr, req_wdata, req_be  request fields (byte address)
//   resp_valid           one-cycle response pulse
//   resp_rdata, resp_err response payload, valid with resp_valid
// -----------------------------------------------------------------------------
interface dmem_latency_ctrl_if #(
   parameter int DATA_W = 32
);
   localparam int BE_W = DATA_W / 8;

   logic              req_valid;
   logic              req_ready;
   logic              req_we;
   logic [31:0]       req_addr;
   logic [DATA_W-1:0] req_wdata;
   logic [BE_W-1:0]   req_be;
   logic              resp_valid;
   logic [DATA_W-1:0] resp_rdata;
   logic              resp_err;

   modport master (
      output req_valid, req_we, req_addr, req_wdata, req_be,
      input  req_ready, resp_valid, resp_rdata, resp_err
   );

   modport slave (
      input  req_valid, req_we, req_addr, req_wdata, req_be,
      output req_ready, resp_valid, resp_rdata, resp_err
   );
endinterface

// File: rtl/dmem_array.sv
// -----------------------------------------------------------------------------
// dmem_array
// DEPTH x DATA_W storage, one shared word index for read and write.
//   clk    clock
//   we     write enable (byte lanes selected by be)
//   idx    word index
//   wdata  write data
//   be     byte-lane strobes
//   rdata  combinational read of mem[idx]
// Contents are not reset.
// -----------------------------------------------------------------------------
module dmem_array
   import dmem_pkg::*;
#(
   parameter int DATA_W = 32,
   parameter int DEPTH  = 64,
   localparam int IDX_W = $clog2(DEPTH),
   localparam int BE_W  = DATA_W / 8
) (
   input  logic              clk,
   input  logic              we,
   input  logic [IDX_W-1:0]  idx,
   input  logic [DATA_W-1:0] wdata,
   input  logic [BE_W-1:0]   be,
   output logic [DATA_W-1:0] rdata
);
   logic [DATA_W-1:0] mem_q [DEPTH];
   logic [DATA_W-1:0] merged_d;

   assign rdata = mem_q[idx];

   // Read-modify-write merge: untouched lanes keep their old bytes.
   always_comb begin
      merged_d = DATA_W'(merge_be(MAX_DATA_W'(rdata), MAX_DATA_W'(wdata), MAX_BE_W'(be)));
   end

   always_ff @(posedge clk) begin
      if (we) begin
         mem_q[idx] <= merged_d;
      end
   end
endmodule

// File: rtl/dmem_latency_ctrl.sv
// -----------------------------------------------------------------------------
// dmem_latency_ctrl
// Data-memory controller with a single outstanding request, configurable
// access latency, byte-lane writes, out-of-range error and TOHOST halt MMIO.
//   clk      clock
//   reset    synchronous active-high reset
//   bus      request/response bus (slave side)
//   stall_o  memory stage must stall (request in flight, not yet answered)
//   halt     sticky: TOHOST written with a nonzero value
//   tohost   last value written to TOHOST_ADDR
// Timing: accept in cycle N, access at the end of cycle N+LATENCY,
// resp_valid in cycle N+LATENCY+1.
// -----------------------------------------------------------------------------
module dmem_latency_ctrl
   import dmem_pkg::*;
#(
   parameter int          DATA_W      = 32,
   parameter int          DEPTH       = 64,
   parameter int          LATENCY     = 2,
   parameter logic [31:0] TOHOST_ADDR = TOHOST_DEFAULT
) (
   input  logic               clk,
   input  logic               reset,
   dmem_latency_ctrl_if.slave bus,
   output logic               stall_o,
   output logic               halt,
   output logic [DATA_W-1:0]  tohost
);
   localparam int              IDX_W    = $clog2(DEPTH);
   localparam int              BE_W     = DATA_W / 8;
   localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(LATENCY - 1);

   state_t            state_q, state_d;
   logic [CNT_W-1:0]  cnt_q, cnt_d;
   logic              we_q, we_d;
   logic [29:0]       waddr_q, waddr_d;
   logic [DATA_W-1:0] wdata_q, wdata_d;
   logic [BE_W-1:0]   be_q, be_d;
   logic [DATA_W-1:0] rdata_q, rdata_d;
   logic              err_q, err_d;
   logic              halt_q, halt_d;
   logic [DATA_W-1:0] tohost_q, tohost_d;

   logic              is_tohost;
   logic              in_range;
   logic              complete;
   logic              mem_we;
   logic [IDX_W-1:0]  mem_idx;
   logic [DATA_W-1:0] mem_rdata;
   logic              unused_addr_lsbs;

   // Byte offset within the word is irrelevant to a word-wide memory.
   assign unused_addr_lsbs = ^bus.req_addr[1:0];

   // Decode works on the captured word address, so request fields that
   // change while BUSY have no effect.
   assign mem_idx   = waddr_q[IDX_W-1:0];
   assign is_tohost = (waddr_q == TOHOST_ADDR[31:2]);
   assign in_range  = (waddr_q[29:IDX_W] == '0) &&
                      ({1'b0, mem_idx} < (IDX_W+1)'(DEPTH));
   assign complete  = (state_q == BUSY) && (cnt_q == '0);

   // TOHOST wins over the array; a reset landing on the completion cycle
   // must drop the pending write.
   assign mem_we = complete && we_q && in_range && !is_tohost && !reset;

   dmem_array #(
      .DATA_W (DATA_W),
      .DEPTH  (DEPTH)
   ) u_array (
      .clk   (clk),
      .we    (mem_we),
      .idx   (mem_idx),
      .wdata (wdata_q),
      .be    (be_q),
      .rdata (mem_rdata)
   );

   always_comb begin
      state_d  = state_q;
      cnt_d    = cnt_q;
      we_d     = we_q;
      waddr_d  = waddr_q;
      wdata_d  = wdata_q;
      be_d     = be_q;
      rdata_d  = rdata_q;
      err_d    = err_q;
      halt_d   = halt_q;
      tohost_d = tohost_q;

      case (state_q)
         IDLE: begin
            // req_ready is high in IDLE, so valid alone means acceptance.
            if (bus.req_valid) begin
               state_d = BUSY;
               cnt_d   = CNT_LOAD;
               we_d    = bus.req_we;
               waddr_d = bus.req_addr[31:2];
               wdata_d = bus.req_wdata;
               be_d    = bus.req_be;
            end
         end
         BUSY: begin
            if (cnt_q == '0) begin
               state_d = RESP;
               rdata_d = '0;
               err_d   = 1'b0;
               if (is_tohost) begin
                  if (we_q) begin
                     tohost_d = wdata_q;
                     halt_d   = halt_q | (wdata_q != '0);
                  end else begin
                     rdata_d = tohost_q;
                  end
               end else if (in_range) begin
                  if (!we_q) begin
                     rdata_d = mem_rdata;
                  end
               end else begin
                  err_d = 1'b1;
               end
            end else begin
               cnt_d = cnt_q - CNT_W'(1);
            end
         end
         RESP: begin
            state_d = IDLE;
         end
         default: begin
            state_d = IDLE;
         end
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q  <= IDLE;
         cnt_q    <= '0;
         we_q     <= 1'b0;
         waddr_q  <= '0;
         wdata_q  <= '0;
         be_q     <= '0;
         rdata_q  <= '0;
         err_q    <= 1'b0;
         halt_q   <= 1'b0;
         tohost_q <= '0;
      end else begin
         state_q  <= state_d;
         cnt_q    <= cnt_d;
         we_q     <= we_d;
         waddr_q  <= waddr_d;
         wdata_q  <= wdata_d;
         be_q     <= be_d;
         rdata_q  <= rdata_d;
         err_q    <= err_d;
         halt_q   <= halt_d;
         tohost_q <= tohost_d;
      end
   end

   assign bus.req_ready  = (state_q == IDLE);
   assign bus.resp_valid = (state_q == RESP);
   assign bus.resp_rdata = rdata_q;
   assign bus.resp_err   = err_q;

   // The response cycle releases the stall so the memory stage can retire
   // the result in the same cycle resp_valid is high.
   assign stall_o = ((bus.req_valid && !bus.req_ready) || (state_q != IDLE)) &&
                    (state_q != RESP);
   assign halt    = halt_q;
   assign tohost  = tohost_q;
endmodule

// File: tb/tb_dmem_latency_ctrl.sv
// -----------------------------------------------------------------------------
// tb_dmem_latency_ctrl
// Three controller instances with LATENCY 2, 1 and 8 share one clock, reset
// and request-field bus; each has its own req_valid. A behavioural model
// (word array, tohost/halt values, cycle-position timeline) supplies every
// expected value.
// -----------------------------------------------------------------------------
`timescale 1ns/1ps
module tb_dmem_latency_ctrl;
   localparam int NI    = 3;
   localparam int DEPTH = 64;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic              reset;
   logic [NI-1:0]     valid_v;
   logic              we_r;
   logic [31:0]       addr_r;
   logic [31:0]       wdata_r;
   logic [3:0]        be_r;

   logic [NI-1:0]         ready_w, resp_valid_w, err_w, stall_w, halt_w;
   logic [NI-1:0][31:0]   rdata_w, tohost_w;

   int checks = 0;
   int errors = 0;

   logic [31:0] mem_m    [NI][DEPTH];
   logic [31:0] tohost_m [NI];
   logic        halt_m   [NI];

   function automatic int lat_of(input int k);
      return (k == 0) ? 2 : ((k == 1) ? 1 : 8);
   endfunction

   generate
      for (genvar gi = 0; gi < NI; gi++) begin : g_dut
         localparam int L = (gi == 0) ? 2 : ((gi == 1) ? 1 : 8);
         dmem_latency_ctrl_if #(.DATA_W(32)) bus ();
         assign bus.req_valid     = valid_v[gi];
         assign bus.req_we        = we_r;
         assign bus.req_addr      = addr_r;
         assign bus.req_wdata     = wdata_r;
         assign bus.req_be        = be_r;
         assign ready_w[gi]       = bus.req_ready;
         assign resp_valid_w[gi]  = bus.resp_valid;
         assign rdata_w[gi]       = bus.resp_rdata;
         assign err_w[gi]         = bus.resp_err;
         dmem_latency_ctrl #(
            .DATA_W      (32),
            .DEPTH       (DEPTH),
            .LATENCY     (L),
            .TOHOST_ADDR (32'h0000_1000)
         ) dut (
            .clk     (clk),
            .reset   (reset),
            .bus     (bus.slave),
            .stall_o (stall_w[gi]),
            .halt    (halt_w[gi]),
            .tohost  (tohost_w[gi])
         );
      end
   endgenerate

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   // 0 = array word, 1 = TOHOST, 2 = out of range
   function automatic int kind_of(input logic [31:0] a);
      if (a[31:2] == 30'h400) return 1;
      if (a < 32'(4 * DEPTH)) return 0;
      return 2;
   endfunction

   // One complete transaction on instance k. Entered and left 1 ns after a
   // rising edge; returns the observed response data.
   task automatic do_req(input int k, input logic we, input logic [31:0] addr,
                         input logic [31:0] wdata, input logic [3:0] be,
                         output logic [31:0] rd);
      int          kind, idx, lat;
      bit          got;
      logic [31:0] exp_rd;
      kind   = kind_of(addr);
      idx    = int'(addr[7:2]);
      exp_rd = '0;
      if (!we && kind == 0) exp_rd = mem_m[k][idx];
      if (!we && kind == 1) exp_rd = tohost_m[k];

      valid_v[k] = 1'b1; we_r = we; addr_r = addr; wdata_r = wdata; be_r = be;
      got = 1'b0;
      for (int c = 0; c < 20; c++) begin
         @(negedge clk);
         if (ready_w[k]) begin got = 1'b1; break; end
      end
      chk("accept", 32'(got), 32'd1);
      @(posedge clk); #1;
      valid_v[k] = 1'b0;
      // Scramble the request fields while the transaction is in flight.
      we_r = 1'($urandom); addr_r = $urandom; wdata_r = $urandom; be_r = 4'($urandom);

      got = 1'b0; lat = 0;
      for (int c = 1; c <= 20; c++) begin
         @(negedge clk);
         if (resp_valid_w[k]) begin got = 1'b1; lat = c; break; end
         chk("stall_busy", 32'(stall_w[k]), 32'd1);
      end
      chk("resp_latency", 32'(lat), 32'(lat_of(k) + 1));

      if (we && kind == 0) begin
         for (int b = 0; b < 4; b++) begin
            if (be[b]) mem_m[k][idx][b*8 +: 8] = wdata[b*8 +: 8];
         end
      end
      if (we && kind == 1) begin
         tohost_m[k] = wdata;
         halt_m[k]   = halt_m[k] | (wdata != 32'd0);
      end

      rd = rdata_w[k];
      if (got) begin
         chk("resp_rdata", rdata_w[k], exp_rd);
         chk("resp_err", 32'(err_w[k]), 32'(kind == 2));
         chk("stall_resp", 32'(stall_w[k]), 32'd0);
         chk("halt", 32'(halt_w[k]), 32'(halt_m[k]));
         chk("tohost", tohost_w[k], tohost_m[k]);
         $display("txn inst%0d lat%0d we=%0d addr=%h wdata=%h be=%h -> rdata=%h err=%0d",
                  k, lat_of(k), we, addr, wdata, be, rdata_w[k], err_w[k]);
      end
      @(posedge clk); #1;
   endtask

   // Reads of 0x10 with req_valid held high: checks the per-cycle ready /
   // stall / resp pattern of period LATENCY+2 against a position timeline.
   task automatic b2b(input int k, input int periods);
      int L, p, dut_resps;
      L = lat_of(k);
      valid_v[k] = 1'b1; we_r = 1'b0; addr_r = 32'h10; wdata_r = '0; be_r = '0;
      p = L + 2;
      dut_resps = 0;
      for (int c = 0; c < periods * (L + 2); c++) begin
         @(negedge clk);
         if (p >= L + 2) p = 0;
         chk("b2b_ready", 32'(ready_w[k]), 32'(p == 0));
         chk("b2b_stall", 32'(stall_w[k]), 32'(p >= 1 && p <= L));
         chk("b2b_resp", 32'(resp_valid_w[k]), 32'(p == L + 1));
         if (resp_valid_w[k]) begin
            dut_resps++;
            chk("b2b_rdata", rdata_w[k], mem_m[k][4]);
         end
         p++;
      end
      @(posedge clk); #1;
      valid_v[k] = 1'b0;
      chk("b2b_resp_count", 32'(dut_resps), 32'(periods));
      $display("txn inst%0d lat%0d back-to-back %0d periods, %0d responses", k, L, periods, dut_resps);
   endtask

   initial begin
      #1_000_000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1, "watchdog");
   end

   initial begin
      logic [31:0] rd;
      logic [31:0] a, d;
      int          sel;
      reset = 1'b1; valid_v = '0; we_r = 1'b0; addr_r = '0; wdata_r = '0; be_r = '0;
      for (int k = 0; k < NI; k++) begin
         tohost_m[k] = '0;
         halt_m[k]   = 1'b0;
      end
      repeat (3) @(posedge clk);
      #1 reset = 1'b0;

      // Reset state
      @(negedge clk);
      for (int k = 0; k < NI; k++) begin
         chk("rst_ready", 32'(ready_w[k]), 32'd1);
         chk("rst_resp_valid", 32'(resp_valid_w[k]), 32'd0);
         chk("rst_rdata", rdata_w[k], 32'd0);
         chk("rst_err", 32'(err_w[k]), 32'd0);
         chk("rst_stall", 32'(stall_w[k]), 32'd0);
         chk("rst_halt", 32'(halt_w[k]), 32'd0);
         chk("rst_tohost", tohost_w[k], 32'd0);
      end
      @(posedge clk); #1;

      // Fill every word so later reads have defined expectations.
      for (int k = 0; k < NI; k++) begin
         for (int i = 0; i < DEPTH; i++) begin
            do_req(k, 1'b1, 32'(i * 4), $urandom, 4'hF, rd);
         end
      end

      // Directed: full write, read back, partial write merge.
      do_req(0, 1'b1, 32'h10, 32'hDEADBEEF, 4'hF, rd);
      do_req(0, 1'b0, 32'h10, 32'h0, 4'h0, rd);
      chk("read_deadbeef", rd, 32'hDEADBEEF);
      do_req(0, 1'b1, 32'h12, 32'h11223344, 4'b0101, rd);
      do_req(0, 1'b0, 32'h10, 32'h0, 4'h0, rd);
      chk("read_merged", rd, 32'hDE22BE44);
      do_req(0, 1'b1, 32'h14, 32'h55555555, 4'h0, rd);
      do_req(0, 1'b0, 32'h14, 32'h0, 4'h0, rd);

      // Out of range: error, and no aliasing into word 0.
      do_req(0, 1'b0, 32'h100, 32'h0, 4'h0, rd);
      do_req(0, 1'b1, 32'h100, 32'hA5A5A5A5, 4'hF, rd);
      do_req(0, 1'b0, 32'h0, 32'h0, 4'h0, rd);
      do_req(0, 1'b0, 32'h0, 32'h0, 4'h0, rd);

      // TOHOST: zero does not halt, nonzero does, halt stays set.
      do_req(0, 1'b1, 32'h1000, 32'h0, 4'hF, rd);
      chk("halt_after_zero", 32'(halt_w[0]), 32'd0);
      do_req(0, 1'b1, 32'h1000, 32'h1, 4'h0, rd);
      chk("halt_after_one", 32'(halt_w[0]), 32'd1);
      chk("tohost_one", tohost_w[0], 32'd1);
      do_req(0, 1'b1, 32'h1000, 32'h0, 4'hF, rd);
      chk("halt_sticky", 32'(halt_w[0]), 32'd1);
      do_req(0, 1'b0, 32'h1000, 32'h0, 4'h0, rd);

      // Reset on the completion cycle of a write to 0x20.
      do_req(0, 1'b1, 32'h20, 32'hCAFE0001, 4'hF, rd);
      valid_v[0] = 1'b1; we_r = 1'b1; addr_r = 32'h20; wdata_r = 32'h0BAD0BAD; be_r = 4'hF;
      @(posedge clk); #1;
      valid_v[0] = 1'b0;
      @(posedge clk); #1;
      reset = 1'b1;
      @(posedge clk); #1;
      reset = 1'b0;
      for (int k = 0; k < NI; k++) begin
         tohost_m[k] = '0;
         halt_m[k]   = 1'b0;
      end
      for (int c = 0; c < 12; c++) begin
         @(negedge clk);
         chk("no_resp_after_reset", 32'(resp_valid_w[0]), 32'd0);
      end
      chk("ready_after_reset", 32'(ready_w[0]), 32'd1);
      chk("halt_cleared", 32'(halt_w[0]), 32'd0);
      $display("txn inst0 reset during write to 0x20");
      @(posedge clk); #1;
      do_req(0, 1'b0, 32'h20, 32'h0, 4'h0, rd);
      chk("write_discarded", rd, 32'hCAFE0001);

      // Randomised traffic on every latency.
      for (int k = 0; k < NI; k++) begin
         for (int n = 0; n < 30; n++) begin
            sel = int'($urandom_range(0, 9));
            if (sel < 7)       a = 32'($urandom_range(0, DEPTH - 1)) * 4 + 32'($urandom_range(0, 3));
            else if (sel == 7) a = 32'h100 + 32'($urandom_range(0, 3));
            else if (sel == 8) a = 32'h8000_0000 | $urandom;
            else               a = 32'h1000 + 32'($urandom_range(0, 3));
            d = ($urandom_range(0, 1) == 1) ? $urandom : 32'd0;
            do_req(k, 1'($urandom_range(0, 1)), a, d, 4'($urandom_range(0, 15)), rd);
         end
      end

      // Back-to-back with valid held high at LATENCY 1 and 8.
      b2b(1, 6);
      b2b(2, 4);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule
